// File: rtl/dff_bank_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dff_bank_rr_arbiter
//
// Shares one WIDTH-bit register bank between NREQ requesters. Grants rotate
// round-robin. A granted requester may write the bank on consecutive cycles
// for up to MAX_HOLD writes. Every release passes through one IDLE cycle, so
// there is no combinational path from req to gnt.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req        per-requester write request (level)
//   wr_data    requester i data in bits [i*WIDTH +: WIDTH]
//   gnt        one-hot grant (registered)
//   q          shared register bank contents
//   q_valid    high once the bank has been written since reset
//   wr_strobe  high for the cycle after each bank write
//   owner      index of the requester that performed the last write
// -----------------------------------------------------------------------------
module dff_bank_rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wr_data,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        q,
  output logic                    q_valid,
  output logic                    wr_strobe,
  output logic [$clog2(NREQ)-1:0] owner
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
  localparam logic [IW:0]   NREQ_W   = (IW+1)'(NREQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]     gidx_q, gidx_d;   // index of the current grant holder
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  bank_q, bank_d;
  logic              valid_q, valid_d;
  logic              strobe_q, strobe_d;
  logic [IW-1:0]     owner_q, owner_d;

  // Unpacked view of the requester data lanes.
  logic [WIDTH-1:0]  wdata [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign wdata[gi] = wr_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Rotating priority search: first set req bit at ptr, ptr+1, ... mod NREQ.
  logic [IW-1:0] sel_idx;
  logic          sel_found;
  logic [IW:0]   cand;

  always_comb begin
    sel_idx   = ptr_q;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!sel_found && req[cand[IW-1:0]]) begin
        sel_idx   = cand[IW-1:0];
        sel_found = 1'b1;
      end
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    bank_d   = bank_q;
    valid_d  = valid_q;
    owner_d  = owner_q;
    strobe_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (sel_found) begin
          gnt_d[sel_idx] = 1'b1;
          gidx_d         = sel_idx;
          cnt_d          = '0;
          state_d        = GRANT;
        end
      end

      GRANT: begin
        // Release whenever the holder drops its request or uses its last
        // write; the pointer moves past the holder for fairness.
        if (req[gidx_q]) begin
          bank_d   = wdata[gidx_q];
          owner_d  = gidx_q;
          valid_d  = 1'b1;
          strobe_d = 1'b1;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            gnt_d   = '0;
            ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + IW'(1);
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d   = '0;
          gnt_d   = '0;
          ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + IW'(1);
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gidx_q   <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      bank_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      bank_q   <= bank_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      owner_q  <= owner_d;
    end
  end

  assign gnt       = gnt_q;
  assign q         = bank_q;
  assign q_valid   = valid_q;
  assign wr_strobe = strobe_q;
  assign owner     = owner_q;

endmodule
